serial_add_ctrl: RTL and testbench
==================================

# serial_add_ctrl

Sequencer that performs wide add/subtract operations by time-sharing a single 4-bit nibble adder across NIBBLES cycles, rippling the carry through a register between cycles. It sits between an operand-issuing requester and a result consumer. Both sides use valid/ready handshakes. It replaces a wide combinational adder where area matters more than latency.

## Interface
- NIBBLES, default 4: operand width in nibbles; W = 4*NIBBLES; legal range 1..16.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  requester presents an operation.
- in_ready  out  1  block can accept an operation.
- op_a  in  [0:W-1]  operand A; index 0 is the MSB.
- op_b  in  [0:W-1]  operand B; index 0 is the MSB.
- cin  in  1  carry-in for add; ignored for subtract.
- sub  in  1  0 selects A+B+cin; 1 selects A-B.
- out_valid  out  1  result held and valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  [0:W-1]  result; index 0 is the MSB.
- carry  out  1  add: carry out; sub: 1 = no borrow (A>=B unsigned).

## Operation
- States are IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, capture op_a, op_b and sub.
  - Initial carry register = sub ? 1 : cin.
  - Nibble index = 0; go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, nibble_adder adds nibble k of A with nibble k of B (inverted when sub) plus the carry register.
  - Nibble 0 is the least-significant nibble, bits [W-4:W-1].
  - At the edge, the 4-bit result is written to sum nibble k, the adder carry-out goes to the carry register, and k increments.
  - After the edge that writes nibble NIBBLES-1, go to DONE.
- DONE:
  - out_valid=1; sum and carry hold stable.
  - On out_ready, go to IDLE.
  - A new operation is not accepted in the same cycle.
- Arithmetic is modulo 2^W unsigned.
  - Add: {carry,sum} = op_a+op_b+cin.
  - Sub: {carry,sum} = op_a + ~op_b + 1.
- in_valid while busy: ignored. The requester must hold its operands until in_ready.
- Input changes after the accept edge have no effect on the operation in flight.

## Timing
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0, sum=0, carry=0.
  - Carry register=0, nibble index=0.
- Reset asserted mid-RUN or in DONE aborts immediately. The result is lost and no out_valid pulse occurs.
- Latency: accept at edge T; out_valid rises after edge T+NIBBLES.
- Throughput: one operation per NIBBLES+2 cycles when out_ready is tied high.
  - One DONE cycle, then one IDLE cycle to accept.
- out_ready high on the cycle out_valid rises: the result is consumed at that edge and the block returns to IDLE.
- NIBBLES=1: RUN lasts exactly one cycle.
- Index wrap: the counter never exceeds NIBBLES-1. Its width is clog2(NIBBLES), minimum 1 bit.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package serial_add_pkg holds:
  - NIBBLE_W=4.
  - The state enum {IDLE, RUN, DONE}.
  - A clog2-based index width function.
- Sub-module nibble_adder is purely combinational:
  - Inputs: a[0:3], b[0:3], cin.
  - Outputs: sum[0:3], carry.
  - Behaviour: {carry,sum}=a+b+cin.
- The top level holds:
  - The FSM.
  - Operand registers, shifted right one nibble per RUN cycle, so nibble_adder always reads the lowest nibble.
  - The result register, filled by shifting in from the MSB side.
  - The carry register.

## Test plan
- NIBBLES=4, add 0x1234+0x0FFF, cin=0 -> sum=0x2233, carry=0, out_valid 4 cycles after accept.
- Add 0xFFFF+0x0000, cin=1 -> sum=0x0000, carry=1. This exercises carry ripple through all nibbles.
- Sub 0x0005-0x0007, cin=1 (ignored) -> sum=0xFFFE, carry=0. Then sub 0x0007-0x0005 -> sum=0x0002, carry=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> sum and carry stable, in_ready=0, and a second in_valid is ignored. Raise out_ready -> IDLE next cycle, then accept the second operation.
- Assert rst in the 2nd RUN cycle -> all outputs 0 and in_ready=1 without waiting for an edge. Then a fresh 0x0001+0x0001 yields 0x0002.
- NIBBLES=1: 0xF+0x1, cin=0 -> sum=0x0, carry=1, out_valid one cycle after accept. Sweep all 512 {cin,a,b} combinations against a reference model.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer.
// Holds the nibble width, the FSM state type and the index width helper.
package serial_add_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Width of the nibble index counter; never narrower than one bit.
    function automatic int idx_width(input int nibbles);
        return (nibbles <= 2) ? 1 : $clog2(nibbles);
    endfunction

endpackage

// File: rtl/nibble_adder.sv
// Purely combinational 4-bit adder with carry-in and carry-out.
// Index 0 of every vector is the MSB.
module nibble_adder
    import serial_add_pkg::*;
(
    input  logic [0:NIBBLE_W-1] a,
    input  logic [0:NIBBLE_W-1] b,
    input  logic                cin,
    output logic [0:NIBBLE_W-1] sum,
    output logic                carry
);

    assign {carry, sum} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};

endmodule

// File: rtl/serial_add_ctrl.sv
// Wide add/subtract built from one shared nibble adder, one nibble per cycle,
// with valid/ready handshakes on both the operand and the result side.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int NIBBLES = 4
)
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [0:NIBBLE_W*NIBBLES-1]   op_a,
    input  logic [0:NIBBLE_W*NIBBLES-1]   op_b,
    input  logic                          cin,
    input  logic                          sub,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [0:NIBBLE_W*NIBBLES-1]   sum,
    output logic                          carry
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = idx_width(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t              state;
    logic [0:W-1]        reg_a;
    logic [0:W-1]        reg_b;
    logic                sub_reg;
    logic                carry_reg;
    logic [IDX_W-1:0]    idx;

    logic [0:NIBBLE_W-1] nib_a;
    logic [0:NIBBLE_W-1] nib_b;
    logic [0:NIBBLE_W-1] nib_sum;
    logic                nib_carry;

    // Operands shift toward the LSB each RUN cycle, so the adder always sees the lowest nibble.
    assign nib_a = reg_a[W-NIBBLE_W +: NIBBLE_W];
    assign nib_b = sub_reg ? ~reg_b[W-NIBBLE_W +: NIBBLE_W] : reg_b[W-NIBBLE_W +: NIBBLE_W];

    nibble_adder u_nibble_adder (
        .a     (nib_a),
        .b     (nib_b),
        .cin   (carry_reg),
        .sum   (nib_sum),
        .carry (nib_carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            carry     <= 1'b0;
            carry_reg <= 1'b0;
            idx       <= '0;
            reg_a     <= '0;
            reg_b     <= '0;
            sub_reg   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        reg_a     <= op_a;
                        reg_b     <= op_b;
                        sub_reg   <= sub;
                        carry_reg <= sub ? 1'b1 : cin;
                        idx       <= '0;
                        in_ready  <= 1'b0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    // Each new nibble enters at the MSB end; after NIBBLES cycles the result is aligned.
                    reg_a     <= reg_a >> NIBBLE_W;
                    reg_b     <= reg_b >> NIBBLE_W;
                    sum       <= (sum >> NIBBLE_W) | (W'(nib_sum) << (W - NIBBLE_W));
                    carry_reg <= nib_carry;
                    if (idx == LAST_IDX) begin
                        idx       <= '0;
                        carry     <= nib_carry;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: a 4-nibble instance for the directed
// cases and a 1-nibble instance for the exhaustive single-nibble sweep.
module tb_serial_add_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        in_valid4, in_ready4, cin4, sub4, out_valid4, out_ready4, carry4;
    logic [0:15] op_a4, op_b4, sum4;

    logic        in_valid1, in_ready1, cin1, sub1, out_valid1, out_ready1, carry1;
    logic [0:3]  op_a1, op_b1, sum1;

    int errors = 0;
    int checks = 0;

    logic [16:0] sb4[$];
    logic [4:0]  sb1[$];

    serial_add_ctrl #(.NIBBLES(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .op_a      (op_a4),
        .op_b      (op_b4),
        .cin       (cin4),
        .sub       (sub4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .sum       (sum4),
        .carry     (carry4)
    );

    serial_add_ctrl #(.NIBBLES(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .op_a      (op_a1),
        .op_b      (op_b1),
        .cin       (cin1),
        .sub       (sub1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .sum       (sum1),
        .carry     (carry1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Presents one operation to the 4-nibble instance and returns 1ns after the accept edge.
    task automatic applyStimulus4(input logic [15:0] a, input logic [15:0] b,
                                  input logic c, input logic s);
        int guard = 0;
        op_a4 = a;
        op_b4 = b;
        cin4 = c;
        sub4 = s;
        in_valid4 = 1'b1;
        while (!in_ready4 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("accept_wait", 32'(in_ready4), 32'd1);
        if (s) sb4.push_back({1'b0, a} + {1'b0, ~b} + 17'd1);
        else   sb4.push_back({1'b0, a} + {1'b0, b} + {16'd0, c});
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        op_a4 = 16'($urandom);
        op_b4 = 16'($urandom);
        cin4 = ~c;
        sub4 = ~s;
    endtask

    // Waits for the result, optionally stalls it with out_ready low, then consumes it.
    task automatic drainResult4(input string tag, input int hold);
        int lat = 0;
        logic [16:0] first;
        logic [16:0] exp;
        while (!out_valid4 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput({tag, "_latency"}, 32'(lat), 32'd4);
        first = {carry4, sum4};
        for (int i = 0; i < hold; i++) begin
            checkOutput({tag, "_busy_in_ready"}, 32'(in_ready4), 32'd0);
            @(posedge clk); #1;
            checkOutput({tag, "_stable"}, 32'({carry4, sum4}), 32'(first));
            checkOutput({tag, "_held_valid"}, 32'(out_valid4), 32'd1);
        end
        if (sb4.size() == 0) begin
            checkOutput({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
            exp = '0;
        end else begin
            exp = sb4.pop_front();
        end
        checkOutput({tag, "_result"}, 32'({carry4, sum4}), 32'(exp));
        out_ready4 = 1'b1;
        @(posedge clk); #1;
        out_ready4 = 1'b0;
        checkOutput({tag, "_back_idle_ready"}, 32'(in_ready4), 32'd1);
        checkOutput({tag, "_back_idle_valid"}, 32'(out_valid4), 32'd0);
    endtask

    initial begin
        logic seen;
        int   lat;
        int   guard;
        logic [4:0] exp1;

        rst = 1'b1;
        in_valid4 = 1'b0; op_a4 = '0; op_b4 = '0; cin4 = 1'b0; sub4 = 1'b0; out_ready4 = 1'b0;
        in_valid1 = 1'b0; op_a1 = '0; op_b1 = '0; cin1 = 1'b0; sub1 = 1'b0; out_ready1 = 1'b0;

        #12;
        checkOutput("reset_in_ready", 32'(in_ready4), 32'd1);
        checkOutput("reset_out_valid", 32'(out_valid4), 32'd0);
        checkOutput("reset_sum", 32'(sum4), 32'd0);
        checkOutput("reset_carry", 32'(carry4), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        applyStimulus4(16'h1234, 16'h0FFF, 1'b0, 1'b0);
        drainResult4("add_basic", 0);

        applyStimulus4(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        drainResult4("add_ripple", 0);

        applyStimulus4(16'h0005, 16'h0007, 1'b1, 1'b1);
        drainResult4("sub_borrow", 0);

        applyStimulus4(16'h0007, 16'h0005, 1'b0, 1'b1);
        drainResult4("sub_noborrow", 0);

        // A second request raised while busy must wait until the block is back in IDLE.
        applyStimulus4(16'hA5A5, 16'h1111, 1'b0, 1'b0);
        op_a4 = 16'h8000; op_b4 = 16'h8000; cin4 = 1'b1; sub4 = 1'b0; in_valid4 = 1'b1;
        drainResult4("backpressure", 5);
        applyStimulus4(16'h8000, 16'h8000, 1'b1, 1'b0);
        drainResult4("after_backpressure", 0);

        applyStimulus4(16'h1234, 16'h1111, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checkOutput("abort_sum", 32'(sum4), 32'd0);
        checkOutput("abort_carry", 32'(carry4), 32'd0);
        checkOutput("abort_out_valid", 32'(out_valid4), 32'd0);
        checkOutput("abort_in_ready", 32'(in_ready4), 32'd1);
        if (sb4.size() != 0) void'(sb4.pop_back());
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            seen |= out_valid4;
        end
        checkOutput("abort_no_pulse", 32'(seen), 32'd0);
        applyStimulus4(16'h0001, 16'h0001, 1'b0, 1'b0);
        drainResult4("after_abort", 0);

        out_ready1 = 1'b1;
        for (int c = 0; c < 2; c++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    op_a1 = 4'(a);
                    op_b1 = 4'(b);
                    cin1 = c[0];
                    sub1 = 1'b0;
                    in_valid1 = 1'b1;
                    guard = 0;
                    while (!in_ready1 && guard < 20) begin
                        @(posedge clk); #1;
                        guard++;
                    end
                    sb1.push_back({1'b0, 4'(a)} + {1'b0, 4'(b)} + 5'(c));
                    @(posedge clk); #1;
                    in_valid1 = 1'b0;
                    op_a1 = 4'($urandom);
                    op_b1 = 4'($urandom);
                    lat = 0;
                    while (!out_valid1 && lat < 10) begin
                        @(posedge clk); #1;
                        lat++;
                    end
                    checkOutput("n1_latency", 32'(lat), 32'd1);
                    exp1 = (sb1.size() != 0) ? sb1.pop_front() : 5'd0;
                    checkOutput("n1_result", 32'({carry1, sum1}), 32'(exp1));
                    @(posedge clk); #1;
                end
            end
        end
        out_ready1 = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
